// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-byte ALU operation sequencer.
// Issues one byte per cycle, LSB first, chaining a registered carry.
module alu_seq_ctrl #(
  parameter int MAX_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [2:0]             cmd_len,
  input  logic [8*MAX_BYTES-1:0] cmd_a,
  input  logic [8*MAX_BYTES-1:0] cmd_b,
  input  logic                   cmd_cin,
  output logic [7:0]             alu_a1,
  output logic [7:0]             alu_a2,
  output logic [7:0]             alu_op,
  output logic                   alu_en,
  output logic                   alu_cin,
  input  logic [7:0]             alu_out,
  input  logic                   alu_cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [8*MAX_BYTES-1:0] res_data,
  output logic                   res_carry,
  output logic                   res_err
);

  localparam int W  = 8 * MAX_BYTES;
  localparam int KW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  localparam logic [3:0]    MAXB  = 4'(MAX_BYTES);
  localparam logic [KW-1:0] K_ONE = KW'(1);

  logic [1:0]    state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [2:0]    op_q;
  logic [2:0]    len_q;
  logic          cin_q;
  logic [KW-1:0] k;
  logic          carry;

  logic arith;
  logic last;
  logic illegal;

  assign arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign last    = (3'(k) == (len_q - 3'd1));
  assign illegal = (cmd_op > OP_XOR) || (cmd_len == 3'd0) ||
                   ({1'b0, cmd_len} > MAXB);

  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign res_carry = carry;

  // Drive the ALU only while running; idle it otherwise.
  always_comb begin
    alu_en  = 1'b0;
    alu_op  = 8'h00;
    alu_a1  = 8'h00;
    alu_a2  = 8'h00;
    alu_cin = 1'b0;
    if (state == RUN) begin
      alu_en  = 1'b1;
      alu_op  = 8'h01 << op_q;
      alu_a1  = a_q[{k, 3'b000} +: 8];
      alu_a2  = b_q[{k, 3'b000} +: 8];
      alu_cin = arith & ((k == '0) ? cin_q : carry);
    end
  end

  // Sequencer FSM, operand latch and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'd0;
      len_q    <= 3'd0;
      cin_q    <= 1'b0;
      k        <= '0;
      carry    <= 1'b0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            a_q      <= cmd_a;
            b_q      <= cmd_b;
            op_q     <= cmd_op;
            len_q    <= cmd_len;
            cin_q    <= cmd_cin;
            k        <= '0;
            carry    <= 1'b0;
            res_data <= '0;
            res_err  <= illegal;
            state    <= illegal ? DONE : RUN;
          end
        end
        RUN: begin
          res_data[{k, 3'b000} +: 8] <= alu_out;
          carry <= arith & alu_cout;
          k     <= k + K_ONE;
          if (last) state <= DONE;
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
